// File: rtl/sort_pkg.sv
// Shared definitions for the odd-even transposition sorter: order encoding,
// stage-parity constants and the index-tag width helper.
package sort_pkg;

  typedef enum logic {
    ORD_ASC  = 1'b0,
    ORD_DESC = 1'b1
  } order_e;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

  // Width of an element index tag; never zero, even for a 1-element vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Even stages pair (0,1),(2,3)...; odd stages pair (1,2),(3,4)...
  function automatic int stage_parity(input int k);
    return ((k % 2) == 0) ? PARITY_EVEN : PARITY_ODD;
  endfunction

endpackage

// File: rtl/odd_even_sort_pipe_if.sv
// Vector stream interface for odd_even_sort_pipe: upstream valid/ready with
// data and order select, downstream valid/ready with sorted data, busy flag.
// Optional macro SORT_INDEX_EN adds the o_index tag output.
interface odd_even_sort_pipe_if #(
  parameter int NUM_VALS  = 8,
  parameter int SIZE_DATA = 8
);
  import sort_pkg::*;

`ifdef SORT_INDEX_EN
  localparam int IDX_W = idx_w(NUM_VALS);
`endif

  logic                                i_valid;
  logic                                o_ready;
  logic [NUM_VALS-1:0][SIZE_DATA-1:0]  i_data;
  logic                                i_descend;
  logic                                o_valid;
  logic                                i_ready;
  logic [NUM_VALS-1:0][SIZE_DATA-1:0]  o_data;
  logic                                o_busy;
`ifdef SORT_INDEX_EN
  logic [NUM_VALS-1:0][IDX_W-1:0]      o_index;
`endif

  // Sorter side.
  modport slave (
    input  i_valid, i_data, i_descend, i_ready,
`ifdef SORT_INDEX_EN
    output o_index,
`endif
    output o_ready, o_valid, o_data, o_busy
  );

  // Producer/consumer side.
  modport master (
    output i_valid, i_data, i_descend, i_ready,
`ifdef SORT_INDEX_EN
    input  o_index,
`endif
    input  o_ready, o_valid, o_data, o_busy
  );

endinterface

// File: rtl/cas_unit.sv
// Single compare-exchange cell. Swaps only on strict out-of-order so equal
// elements keep their relative position (stable sort).
module cas_unit
  import sort_pkg::*;
#(
  parameter int SIZE_DATA = 8
) (
  input  logic [SIZE_DATA-1:0] a_i,
  input  logic [SIZE_DATA-1:0] b_i,
  input  logic                 descend_i,
  input  logic                 signed_i,
  output logic [SIZE_DATA-1:0] lo_o,
  output logic [SIZE_DATA-1:0] hi_o,
  output logic                 swap_o
);

  logic a_gt_b;
  logic b_gt_a;

  // Magnitude comparison in the selected number format.
  always_comb begin
    if (signed_i) begin
      a_gt_b = $signed(a_i) > $signed(b_i);
      b_gt_a = $signed(b_i) > $signed(a_i);
    end else begin
      a_gt_b = a_i > b_i;
      b_gt_a = b_i > a_i;
    end
  end

  assign swap_o = (order_e'(descend_i) == ORD_DESC) ? b_gt_a : a_gt_b;
  assign lo_o   = swap_o ? b_i : a_i;
  assign hi_o   = swap_o ? a_i : b_i;

endmodule

// File: rtl/odd_even_sort_pipe.sv
// Pipelined odd-even transposition sorter: NUM_VALS registered stages, one
// vector per cycle, global stall enable driven by the output handshake.
// Optional macro SORT_INDEX_EN carries original-position tags to o_index.
module odd_even_sort_pipe
  import sort_pkg::*;
#(
  parameter int NUM_VALS   = 8,
  parameter int SIZE_DATA  = 8,
  parameter int SIGNED_CMP = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  odd_even_sort_pipe_if.slave bus
);

  localparam logic SGN_MODE = 1'(SIGNED_CMP != 0);

  typedef logic [NUM_VALS-1:0][SIZE_DATA-1:0] vec_t;

  vec_t                data_q  [NUM_VALS];
  vec_t                data_d  [NUM_VALS];
  vec_t                stg_in  [NUM_VALS];
  logic [NUM_VALS-1:0] vld_q;
  logic [NUM_VALS-1:0] vld_d;
  logic [NUM_VALS-2:0] desc_q;
  logic [NUM_VALS-1:0] desc_in;
  logic                ce;

`ifdef SORT_INDEX_EN
  localparam int IDX_W = idx_w(NUM_VALS);
  typedef logic [NUM_VALS-1:0][IDX_W-1:0] tag_t;
  tag_t tag_q  [NUM_VALS];
  tag_t tag_d  [NUM_VALS];
  tag_t tag_in [NUM_VALS];
`endif

  // Whole pipeline moves together; a full output slot blocks everything.
  assign ce      = !vld_q[NUM_VALS-1] || bus.i_ready;
  assign vld_d   = {vld_q[NUM_VALS-2:0], bus.i_valid};
  assign desc_in = {desc_q, bus.i_descend};

  for (genvar k = 0; k < NUM_VALS; k++) begin : g_stage
    localparam int P = stage_parity(k);

    if (k == 0) begin : g_src_in
      assign stg_in[k] = bus.i_data;
`ifdef SORT_INDEX_EN
      for (genvar e = 0; e < NUM_VALS; e++) begin : g_tag_init
        assign tag_in[k][e] = IDX_W'(e);
      end
`endif
    end else begin : g_src_reg
      assign stg_in[k] = data_q[k-1];
`ifdef SORT_INDEX_EN
      assign tag_in[k] = tag_q[k-1];
`endif
    end

    for (genvar j = 0; j < NUM_VALS / 2; j++) begin : g_pair
      localparam int LO = 2 * j + P;
      if (LO + 1 < NUM_VALS) begin : g_cas
`ifdef SORT_INDEX_EN
        logic swap;
`else
        logic swap_unused;
`endif
        cas_unit #(.SIZE_DATA(SIZE_DATA)) u_cas (
          .a_i       (stg_in[k][LO]),
          .b_i       (stg_in[k][LO+1]),
          .descend_i (desc_in[k]),
          .signed_i  (SGN_MODE),
          .lo_o      (data_d[k][LO]),
          .hi_o      (data_d[k][LO+1]),
`ifdef SORT_INDEX_EN
          .swap_o    (swap)
`else
          .swap_o    (swap_unused)
`endif
        );
`ifdef SORT_INDEX_EN
        assign tag_d[k][LO]   = swap ? tag_in[k][LO+1] : tag_in[k][LO];
        assign tag_d[k][LO+1] = swap ? tag_in[k][LO]   : tag_in[k][LO+1];
`endif
      end
    end

    // Odd stages leave the first and last element untouched.
    if (P == PARITY_ODD) begin : g_edge
      assign data_d[k][0]          = stg_in[k][0];
      assign data_d[k][NUM_VALS-1] = stg_in[k][NUM_VALS-1];
`ifdef SORT_INDEX_EN
      assign tag_d[k][0]           = tag_in[k][0];
      assign tag_d[k][NUM_VALS-1]  = tag_in[k][NUM_VALS-1];
`endif
    end
  end

  // Stage registers: valid, order select and data advance on ce; bubbles too.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q  <= '0;
      desc_q <= '0;
      for (int k = 0; k < NUM_VALS; k++) data_q[k] <= '0;
    end else if (ce) begin
      vld_q  <= vld_d;
      desc_q <= desc_in[NUM_VALS-2:0];
      for (int k = 0; k < NUM_VALS; k++) data_q[k] <= data_d[k];
    end
  end

`ifdef SORT_INDEX_EN
  // Position tags follow their elements through every swap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_VALS; k++) tag_q[k] <= '0;
    end else if (ce) begin
      for (int k = 0; k < NUM_VALS; k++) tag_q[k] <= tag_d[k];
    end
  end

  assign bus.o_index = tag_q[NUM_VALS-1];
`endif

  assign bus.o_ready = ce;
  assign bus.o_valid = vld_q[NUM_VALS-1];
  assign bus.o_data  = data_q[NUM_VALS-1];
  assign bus.o_busy  = |vld_q;

endmodule

// File: doc/odd_even_sort_pipe.md
ODD_EVEN_SORT_PIPE -- requirements
Module: odd_even_sort_pipe

Interface
REQ-001 SHALL have parameter NUM_VALS, default 8, number of elements per vector (even, >= 2).
REQ-002 SHALL have parameter SIZE_DATA, default 8, bits per element.
REQ-003 SHALL have parameter SIGNED_CMP, default 0, 1 = two's-complement compare, 0 = unsigned.
REQ-004 i_clk  input  1  single clock, rising edge; one clock, no other clock domains.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_valid  input  1  input vector valid.
REQ-007 o_ready  output  1  block accepts input this cycle.
REQ-008 i_data  input  NUM_VALS x SIZE_DATA (packed array)  unsorted vector, element 0 in LSBs.
REQ-009 i_descend  input  1  per-vector order select, 0 ascending, 1 descending; sampled with i_data.
REQ-010 o_valid  output  1  sorted vector valid.
REQ-011 i_ready  input  1  downstream accepts output.
REQ-012 o_data  output  NUM_VALS x SIZE_DATA  sorted vector, element 0 smallest (ascending) or largest (descending).
REQ-013 o_busy  output  1  any pipeline stage holds a valid vector.

Function
REQ-014 Input transfer SHALL occur when i_valid && o_ready; output transfer when o_valid && i_ready.
REQ-015 Pipeline SHALL be NUM_VALS registered odd-even transposition stages; stage k compares pairs (j, j+1) with j even for k even, j odd for k odd.
REQ-016 Each compare-exchange SHALL swap only on strict out-of-order (a > b ascending, a < b descending), making the sort stable.
REQ-017 i_descend SHALL travel with its vector through every stage; vectors of different order may be in flight simultaneously.
REQ-018 Latency SHALL be exactly NUM_VALS cycles from input transfer to o_valid, with no stall.
REQ-019 Throughput SHALL be one vector per cycle while i_ready = 1.
REQ-020 Global advance enable SHALL be ce = !o_valid || i_ready; o_ready = ce; all stages and their valid bits advance only when ce = 1.
REQ-021 When ce = 0, o_data and o_valid SHALL hold stable (AXI-style stability rule).
REQ-022 Stages with valid = 0 SHALL still advance when ce = 1 (bubbles propagate); data in invalid stages is don't-care but SHALL not be X after reset.
REQ-023 Simultaneous input and output transfer in the same cycle SHALL be supported without loss.
REQ-024 Equal elements SHALL never be swapped; an all-equal vector SHALL exit unchanged.
REQ-025 o_busy SHALL be OR of all stage valid bits.

Reset
REQ-026 On i_rst_n = 0 all stage valid bits, o_valid and o_busy SHALL clear to 0 immediately and all data registers to 0.
REQ-027 Vectors in flight at reset SHALL be discarded; o_ready SHALL be 1 during and after reset.
REQ-028 First input transfer SHALL be possible on the first rising edge after reset deassertion.

Configuration
REQ-029 Macro SORT_INDEX_EN: when defined, SHALL add output o_index (NUM_VALS x $clog2(NUM_VALS)) giving each sorted element's original position, tags carried and swapped alongside data.
REQ-030 Without SORT_INDEX_EN, o_index and all tag registers SHALL be absent; data behaviour identical.

Structure
REQ-031 Shared package sort_pkg SHALL hold the element typedef helper, the index width function and the stage-parity constants.
REQ-032 Compare-exchange SHALL be a sub-module cas_unit (inputs a, b, descend, signed mode; outputs lo-slot, hi-slot, swap flag), instantiated per pair per stage by generate.
REQ-033 No behavioural loop SHALL depend on a runtime variable; all loops are elaboration-time bounded.

Verification (NUM_VALS=8, SIZE_DATA=8 unless stated)
REQ-034 Input {7,6,5,4,3,2,1,0} (element 0 = 7), ascend, i_ready=1 -> o_valid after 8 cycles, o_data = {0,1,2,3,4,5,6,7}.
REQ-035 Same input with i_descend=1 followed next cycle by ascend vector {3,3,1,9,0,255,2,8} -> outputs back-to-back: {7..0}, then {0,1,2,3,3,8,9,255}.
REQ-036 SIGNED_CMP=1, input {0x80,0x7F,0x00,0xFF,...} ascending -> -128 first, 127 last; SORT_INDEX_EN on with ties {5,5,5,...} -> o_index = {0,1,...,7}.
REQ-037 Stream 20 random vectors with i_ready toggled randomly -> every output equals reference sort, in order, no loss or duplication, o_data stable while o_valid && !i_ready.
REQ-038 Assert i_rst_n=0 with 5 vectors in flight -> o_valid, o_busy 0 immediately; no stale vector appears after reset release.
